// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bundle: D/E/M hazard sources in, stall/flush and mul/div status out.
// The master side is the pipeline datapath; the slave side is the stall controller.
interface hazard_stall_ctrl_if;
  logic [4:0] rsD;
  logic [4:0] rtD;
  logic       branchD;
  logic       hiloD;
  logic [4:0] writeregE;
  logic       regwriteE;
  logic       memtoregE;
  logic [4:0] writeregM;
  logic       regwriteM;
  logic       memtoregM;
  logic       mdstartE;
  logic       mddivE;
  logic       stallF;
  logic       stallD;
  logic       flushE;
  logic       mdbusy;
  logic       mddone;

  modport master (
    output rsD, rtD, branchD, hiloD,
    output writeregE, regwriteE, memtoregE,
    output writeregM, regwriteM, memtoregM,
    output mdstartE, mddivE,
    input  stallF, stallD, flushE,
    input  mdbusy, mddone
  );

  modport slave (
    input  rsD, rtD, branchD, hiloD,
    input  writeregE, regwriteE, memtoregE,
    input  writeregM, regwriteM, memtoregM,
    input  mdstartE, mddivE,
    output stallF, stallD, flushE,
    output mdbusy, mddone
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller: load-use, mul/div occupancy, optional D-stage branch hazards.
// Define HAZ_BRANCH_EN to stall branches resolved in D on unready operands.
module hazard_stall_ctrl #(
  parameter int MUL_CYC = 4,
  parameter int DIV_CYC = 32,
  parameter int CW      = 6
) (
  input logic clk,
  input logic rst_n,
  hazard_stall_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYC - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYC - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  state_t        state;
  state_t        stateNext;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNext;
  logic          busyQ;
  logic          doneQ;
  logic          lwStall;
  logic          mdStall;
  logic          brStall;
  logic          stall;
  logic          hitE;

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    unique case (state)
      IDLE: begin
        if (hz.mdstartE) begin
          cntNext   = hz.mddivE ? DIV_LD : MUL_LD;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) stateNext = DONE;
        else cntNext = cnt - ONE;
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // status flags are registered copies of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busyQ <= 1'b0;
      doneQ <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      busyQ <= (stateNext != IDLE);
      doneQ <= (stateNext == DONE);
    end
  end

  assign hitE = (hz.writeregE != 5'd0) &&
                ((hz.writeregE == hz.rsD) ||
                 (hz.writeregE == hz.rtD));

  assign lwStall = hz.regwriteE & hz.memtoregE & hitE;

  assign mdStall = hz.hiloD &
                   (hz.mdstartE | (state != IDLE));

`ifdef HAZ_BRANCH_EN
  logic hitM;

  assign hitM = (hz.writeregM != 5'd0) &&
                ((hz.writeregM == hz.rsD) ||
                 (hz.writeregM == hz.rtD));

  assign brStall = hz.branchD &
                   ((hz.regwriteE & hitE) |
                    (hz.regwriteM & hz.memtoregM & hitM));
`else
  // branches resolve in E; the M-stage and branch inputs stay referenced only
  assign brStall = 1'b0 &
                   (hz.branchD | hz.regwriteM |
                    hz.memtoregM | (|hz.writeregM));
`endif

  assign stall     = lwStall | mdStall | brStall;
  assign hz.stallF = stall;
  assign hz.stallD = stall;
  assign hz.flushE = stall;
  assign hz.mdbusy = busyQ;
  assign hz.mddone = doneQ;

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline stall/flush controller for the 5-stage MIPS core, the sequencing counterpart of the E-stage forwarding unit. It covers the hazards that forwarding cannot resolve: load-use, multiply/divide occupancy and, optionally, decode-stage branch-operand hazards. It tracks the multi-cycle multiply/divide unit with a counter-driven FSM and drives stallF, stallD and flushE for the fetch/decode/execute pipeline registers.

## Interface
Parameters:
- MUL_CYC, 4, multiply latency in busy cycles (1..2^CW-1)
- DIV_CYC, 32, divide latency in busy cycles (1..2^CW-1)
- CW, 6, busy-counter width

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- rsD, rtD  in  5  source registers of the instruction in D
- branchD  in  1  D holds beq/bne (compare resolved in D)
- hiloD  in  1  D holds mfhi/mflo/mthi/mtlo/mult/multu/div/divu
- writeregE  in  5  destination register in E
- regwriteE, memtoregE  in  1  E writes a register / E is a load
- writeregM  in  5  destination register in M
- regwriteM, memtoregM  in  1  M writes a register / M is a load
- mdstartE  in  1  mult/div issuing from E this cycle
- mddivE  in  1  1 = divide, 0 = multiply (valid with mdstartE)
- stallF, stallD  out  1  hold PC / hold the F/D register
- flushE  out  1  clear the D/E register (bubble)
- mdbusy  out  1  registered; unit occupied (state != IDLE)
- mddone  out  1  registered; one-cycle HI/LO write strobe

## Operation
- FSM states: IDLE, BUSY, DONE; a CW-bit down-counter cnt.
- IDLE: on mdstartE, load cnt = (mddivE ? DIV_CYC : MUL_CYC) - 1 and go to BUSY.
- BUSY: if cnt == 0, go to DONE; otherwise cnt decrements by 1.
- DONE: mddone = 1 for this cycle only; next state is IDLE.
- mdstartE outside IDLE is ignored (no reload). It cannot legally occur, because hiloD stalls D.
- lwstall = regwriteE & memtoregE & (writeregE != 0) & (writeregE == rsD | writeregE == rtD).
- mdstall = hiloD & (mdstartE | state != IDLE).
- brstall: see Configuration.
- stall = lwstall | mdstall | brstall; stallF = stallD = flushE = stall.
- Register $0 never causes a hazard.
- All comparisons are 5-bit equality. The counter never wraps, because the load value is at most 2^CW - 2.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, cnt = 0, mdbusy = 0, mddone = 0. stall outputs are then a pure function of the inputs with state = IDLE.
- Reset mid-operation: state returns to IDLE immediately; mddone is not asserted for the aborted operation.
- Stall outputs are combinational, with zero-cycle latency from inputs and state.
- mdstartE high in cycle t:
  - BUSY for cycles t+1 .. t+N (N = MUL_CYC or DIV_CYC);
  - DONE and mddone = 1 at t+N+1;
  - IDLE at t+N+2.
- mdbusy = 1 from t+1 through t+N+1.
- A hiloD instruction present from cycle t is stalled in t .. t+N+1 and advances at the edge ending t+N+1. It therefore reads HI/LO after the DONE write.
- Load-use: a single-cycle stall. The next cycle, the load is in M and forwarding covers it.
- Simultaneous lwstall and mdstall: a single combined stall; the FSM keeps advancing during stalls.

## Configuration
- HAZ_BRANCH_EN defined: brstall = branchD & ((regwriteE & writeregE != 0 & (writeregE == rsD | writeregE == rtD)) | (regwriteM & memtoregM & writeregM != 0 & (writeregM == rsD | writeregM == rtD))). This supports branches resolved in D with D-stage forwarding.
- HAZ_BRANCH_EN undefined: brstall = 0, and branchD is unused (branches resolve in E and are handled by forwarding).

## Test plan
- Reset: hold rst_n = 0 during BUSY with cnt = 10 → mdbusy = 0, mddone = 0, state IDLE immediately; release → no mddone pulse.
- Load-use: regwriteE = memtoregE = 1, writeregE = 5, rsD = 5 → stallF = stallD = flushE = 1 for exactly one cycle. Repeat with writeregE = 0, rsD = 0 → no stall.
- Multiply: mdstartE = 1, mddivE = 0 at cycle t, hiloD = 1 from t → stall in t .. t+5, mddone = 1 at t+5 only, mdbusy = 1 over t+1 .. t+5.
- Divide: mddivE = 1 → mddone at t+33; mdbusy high for 33 cycles. A second mdstartE pulse during BUSY → no counter reload.
- Branch (HAZ_BRANCH_EN): branchD = 1, rtD = 7, regwriteE = 1, writeregE = 7 → stall = 1. The same stimulus with the macro undefined → stall = 0.
- Overlap: lwstall and mdstall both active in the same cycle → one stall; the FSM still reaches DONE on schedule.
